instr_loader: RTL and testbench

Streams a program into the instruction memory. It is the write side of the instruction-fetch path: the core only reads instructions, and this block writes them. It receives a byte-framed program over a valid/ready handshake, assembles 16-bit instructions, and writes them into consecutive instruction-memory addresses. While loading, it holds the core stalled through `core_run`.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/instr_loader_if.sv | 22 ++
 rtl/loader_checksum.sv | 31 +++
 rtl/instr_loader.sv | 136 +++++++++++++
 tb/tb_instr_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types for the instruction loader: FSM state encoding and frame field sizes.
package loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } loader_state_e;

  // States in which a stream byte can be consumed.
  function automatic logic is_rx_state(input loader_state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input (valid/ready) and instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory side.
interface instr_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                                in_valid;
  logic [7:0]                          in_byte;
  logic                                in_ready;
  logic                                imem_we;
  logic [ADDR_WIDTH-1:0]               imem_addr;
  logic [loader_pkg::WORD_BYTES*8-1:0] imem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/loader_checksum.sv
// 8-bit running XOR of accepted stream bytes; clear has priority over enable.
// Result reflects all bytes enabled up to the previous clock edge.
module loader_checksum (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] din_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q ^ din_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/instr_loader.sv
// Assembles a length-prefixed byte stream into 16-bit words and writes them to instruction memory,
// one registered write per LO byte; core_run is held low until a load completes. Optional trailing XOR check: LOADER_CHECKSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  instr_loader_if.slave  bus,
  output logic           core_run,
  output logic           busy,
  output logic           error
);
  localparam int          IDX_W  = ADDR_WIDTH + 1;
  localparam int          LEN_W  = LEN_BYTES * 8;
  localparam int          WORD_W = WORD_BYTES * 8;
  localparam logic [31:0] DEPTH  = 32'd1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;

  logic             rx;
  logic             accept;
  logic             load_start;
  logic [LEN_W-1:0] len_rx;

  assign rx         = is_rx_state(state_q);
  assign accept     = bus.in_valid && rx;
  assign load_start = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign len_rx     = {len_q[LEN_W-1:8], bus.in_byte};

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e END_STATE = S_CHECK;
  logic [7:0] csum;

  loader_checksum u_csum (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (load_start),
    .en_i    (accept && (state_q != S_CHECK)),
    .din_i   (bus.in_byte),
    .sum_o   (csum)
  );
`else
  localparam loader_state_e END_STATE = S_DONE;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (load_start) begin
      state_d = S_LEN_HI;
      idx_d   = '0;
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: begin
          len_d[LEN_W-1 -: 8] = bus.in_byte;
          state_d             = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_rx;
          if (len_rx == '0) begin
            state_d = END_STATE;
          end else if (32'(len_rx) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = bus.in_byte;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          wdata_d = {hi_q, bus.in_byte};
          idx_d   = idx_q + IDX_W'(1);
          // Index is one bit wider than the address so N == DEPTH terminates without wrapping.
          state_d = (32'(idx_d) == 32'(len_q)) ? END_STATE : S_DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          state_d = (bus.in_byte == csum) ? S_DONE : S_ERR;
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready   = rx;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign core_run = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  // The final write strobe lands in DONE, so it must still count as busy.
  assign busy     = rx || we_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected memory writes are queued by the stimulus and
// popped by a negedge monitor; status outputs are checked at #1 after the driving edge.
module tb_instr_loader;
  localparam int AW = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n;
  logic start;
  logic core_run, busy, error;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [7:0] frame[$];

  instr_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .core_run (core_run),
    .busy     (busy),
    .error    (error)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
        check("write_data", 32'(bus.imem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Called at #1 after a rising edge; returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget       = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && budget < 20) begin
      @(posedge clock);
      #1;
      budget++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: got in_ready 0 for byte %0h, expected 1", b);
    end else begin
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(bytes[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
    check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 0);
    check({tag, "_core_run"}, 32'(core_run), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset state and idle after release.
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(3);
    check("post_reset_in_ready", 32'(bus.in_ready), 0);
    check("post_reset_busy", 32'(busy), 0);

    // Nominal two-word load; CHK = 00^02^12^34^AB^CD = 42.
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    check("start_in_ready", 32'(bus.in_ready), 1);
    check("start_busy", 32'(busy), 1);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (CSUM_ON) frame.push_back(8'h42);
    send_frame(frame, 0);
    check("nom_core_run", 32'(core_run), 1);
    check("nom_final_busy", 32'(busy), CSUM_ON ? 0 : 1);
    check("nom_in_ready", 32'(bus.in_ready), 0);
    idle(1);
    check("nom_busy_after", 32'(busy), 0);
    check("nom_core_run_hold", 32'(core_run), 1);
    check("nom_error", 32'(error), 0);
    check("nom_writes_seen", 32'(exp_q.size()), 0);

    // Restart from DONE, random gaps, and a start mid-load that must be ignored.
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    check("restart_core_run_drop", 32'(core_run), 0);
    check("restart_in_ready", 32'(bus.in_ready), 1);
    send_frame('{8'h00, 8'h02}, 3);
    pulse_start();
    check("midload_start_busy", 32'(busy), 1);
    check("midload_start_core_run", 32'(core_run), 0);
    frame = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    if (CSUM_ON) frame.push_back(8'h42);
    send_frame(frame, 3);
    idle(1);
    check("stall_core_run", 32'(core_run), 1);
    check("stall_error", 32'(error), 0);
    check("stall_writes_seen", 32'(exp_q.size()), 0);

    // Zero-length program: no writes, straight to run.
    pulse_start();
    frame = '{8'h00, 8'h00};
    if (CSUM_ON) frame.push_back(8'h00);
    send_frame(frame, 0);
    check("zero_core_run", 32'(core_run), 1);
    check("zero_busy", 32'(busy), 0);
    idle(2);
    check("zero_error", 32'(error), 0);

    // Overflow: N = 257 > DEPTH.
    pulse_start();
    send_frame('{8'h01, 8'h01}, 0);
    check("ovf_error", 32'(error), 1);
    check("ovf_in_ready", 32'(bus.in_ready), 0);
    check("ovf_core_run", 32'(core_run), 0);
    check("ovf_busy", 32'(busy), 0);
    idle(3);
    check("ovf_error_hold", 32'(error), 1);
    check("ovf_in_ready_hold", 32'(bus.in_ready), 0);

    // N = DEPTH fills every address; XOR of all bytes reduces to 01.
    pulse_start();
    check("full_error_cleared", 32'(error), 0);
    frame = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      frame.push_back(8'(i) ^ 8'h5A);
      frame.push_back(8'(i));
      exp_q.push_back({8'(i), 8'(i) ^ 8'h5A, 8'(i)});
    end
    if (CSUM_ON) frame.push_back(8'h01);
    send_frame(frame, 0);
    check("full_core_run", 32'(core_run), 1);
    idle(1);
    check("full_error", 32'(error), 0);
    check("full_last_addr", 32'(bus.imem_addr), 32'hFF);
    check("full_writes_seen", 32'(exp_q.size()), 0);

    if (CSUM_ON) begin
      // Good checksum: 00^01^11^22 = 32.
      exp_q.push_back({8'h00, 16'h1122});
      pulse_start();
      send_frame('{8'h00, 8'h01, 8'h11, 8'h22, 8'h32}, 0);
      check("csum_ok_core_run", 32'(core_run), 1);
      check("csum_ok_error", 32'(error), 0);
      // Bad checksum: word is still written, then ERR.
      exp_q.push_back({8'h00, 16'h1122});
      pulse_start();
      send_frame('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33}, 0);
      check("csum_bad_error", 32'(error), 1);
      check("csum_bad_core_run", 32'(core_run), 0);
      check("csum_bad_in_ready", 32'(bus.in_ready), 0);
      idle(1);
      check("csum_writes_seen", 32'(exp_q.size()), 0);
    end

    // Reset mid-stream clears every output asynchronously.
    pulse_start();
    send_frame('{8'h00, 8'h02, 8'h12}, 0);
    check("midreset_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #2;
    check_all_zero("midreset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);
    check("midreset_in_ready_after", 32'(bus.in_ready), 0);
    check("midreset_core_run_after", 32'(core_run), 0);

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
